// File: rtl/bmp_dp_ram_ctrl.sv
// ---------------------------------------------------------------------------
// bmp_dp_ram_ctrl
//   True dual-port image buffer for the BMP pipelines (header + pixel bytes).
//   A hardware clear sweep writes CLEAR_VALUE to every word after reset
//   and again on request. Reads return data with a configurable latency (1 or 2)
//   and a valid strobe. Out-of-range accesses and same-address write collisions
//   are flagged with one-cycle pulses.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   clr_start             pulse: start a clear sweep (ignored while clr_busy)
//   clr_busy              high while the clear sweep runs; all requests dropped
//   a_ren/a_wen           port A read / write enables
//   a_addr, a_d           port A address and write data
//   a_q, a_qvalid         port A read data (zero unless a_qvalid) and valid
//   a_err                 pulse: port A access with a_addr >= DEPTH
//   b_*                   same as port A for port B
//   coll                  pulse: both ports wrote the same address (A wins)
// ---------------------------------------------------------------------------
module bmp_dp_ram_ctrl #(
  parameter int unsigned          DATA_WIDTH  = 8,
  parameter int unsigned          ADDR_WIDTH  = 20,
  parameter int unsigned          DEPTH       = 786486,
  parameter int unsigned          RD_LATENCY  = 1,
  parameter int unsigned          RDW_MODE    = 0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_start,
  output logic                  clr_busy,
  input  logic                  a_ren,
  input  logic                  a_wen,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_d,
  output logic [DATA_WIDTH-1:0] a_q,
  output logic                  a_qvalid,
  output logic                  a_err,
  input  logic                  b_ren,
  input  logic                  b_wen,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_d,
  output logic [DATA_WIDTH-1:0] b_q,
  output logic                  b_qvalid,
  output logic                  b_err,
  output logic                  coll
);

  // Width of the physical word index; the upper address bits only take part
  // in the range check.
  localparam int unsigned            MAW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]    DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [MAW-1:0]         LAST_IDX  = MAW'(DEPTH - 1);

  typedef enum logic {
    S_CLEAR,
    S_IDLE
  } state_e;

  state_e         state_q;
  logic [MAW-1:0] sweep_q;

  // Clear-sweep controller
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_CLEAR;
      sweep_q <= '0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          if (sweep_q == LAST_IDX) begin
            state_q <= S_IDLE;
            sweep_q <= '0;
          end else begin
            sweep_q <= sweep_q + 1'b1;
          end
        end
        S_IDLE: begin
          if (clr_start) begin
            state_q <= S_CLEAR;
            sweep_q <= '0;
          end
        end
        default: begin
          state_q <= S_CLEAR;
          sweep_q <= '0;
        end
      endcase
    end
  end

  assign clr_busy = (state_q == S_CLEAR);

  // Request qualification
  logic           a_inr, b_inr;
  logic           a_req, b_req;
  logic           a_rd, a_wr, a_oor;
  logic           b_rd, b_wr, b_oor;
  logic           same_wr;
  logic           b_wr_eff;
  logic [MAW-1:0] a_idx, b_idx;

  always_comb begin
    a_inr    = ({1'b0, a_addr} < DEPTH_EXT);
    b_inr    = ({1'b0, b_addr} < DEPTH_EXT);
    a_req    = !clr_busy && (a_ren || a_wen);
    b_req    = !clr_busy && (b_ren || b_wen);
    a_rd     = a_req && a_ren && a_inr;
    a_wr     = a_req && a_wen && a_inr;
    a_oor    = a_req && !a_inr;
    b_rd     = b_req && b_ren && b_inr;
    b_wr     = b_req && b_wen && b_inr;
    b_oor    = b_req && !b_inr;
    same_wr  = a_wr && b_wr && (a_addr == b_addr);
    b_wr_eff = b_wr && !same_wr;
    a_idx    = a_addr[MAW-1:0];
    b_idx    = b_addr[MAW-1:0];
  end

  // Storage: the sweep borrows port A's write path (port requests are
  // dropped while it runs), so each side keeps one read and one write port.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (clr_busy) begin
      mem_q[sweep_q] <= CLEAR_VALUE;
    end else begin
      if (a_wr)     mem_q[a_idx] <= a_d;
      if (b_wr_eff) mem_q[b_idx] <= b_d;
    end
  end

  // Synchronous read registers. The array reads the pre-edge contents, which
  // gives old data for a write on the other port; same-port write-through is
  // selected by RDW_MODE.
  logic [DATA_WIDTH-1:0] a_rdata_q, b_rdata_q;

  always_ff @(posedge clk) begin
    if (a_rd) a_rdata_q <= ((RDW_MODE != 0) && a_wr) ? a_d : mem_q[a_idx];
    if (b_rd) b_rdata_q <= ((RDW_MODE != 0) && b_wr) ? b_d : mem_q[b_idx];
  end

  // Valid pipeline, error and collision pulses. Not gated by clr_busy, so
  // reads accepted before a sweep still complete.
  logic a_v1_q, b_v1_q;
  logic a_err_q, b_err_q, coll_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_v1_q  <= 1'b0;
      b_v1_q  <= 1'b0;
      a_err_q <= 1'b0;
      b_err_q <= 1'b0;
      coll_q  <= 1'b0;
    end else begin
      a_v1_q  <= a_rd;
      b_v1_q  <= b_rd;
      a_err_q <= a_oor;
      b_err_q <= b_oor;
      coll_q  <= same_wr;
    end
  end

  assign a_err = a_err_q;
  assign b_err = b_err_q;
  assign coll  = coll_q;

  generate
    if (RD_LATENCY >= 2) begin : g_lat2
      logic                  a_v2_q, b_v2_q;
      logic [DATA_WIDTH-1:0] a_rdata2_q, b_rdata2_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_v2_q <= 1'b0;
          b_v2_q <= 1'b0;
        end else begin
          a_v2_q <= a_v1_q;
          b_v2_q <= b_v1_q;
        end
      end

      always_ff @(posedge clk) begin
        if (a_v1_q) a_rdata2_q <= a_rdata_q;
        if (b_v1_q) b_rdata2_q <= b_rdata_q;
      end

      assign a_qvalid = a_v2_q;
      assign b_qvalid = b_v2_q;
      assign a_q      = a_v2_q ? a_rdata2_q : '0;
      assign b_q      = b_v2_q ? b_rdata2_q : '0;
    end else begin : g_lat1
      assign a_qvalid = a_v1_q;
      assign b_qvalid = b_v1_q;
      assign a_q      = a_v1_q ? a_rdata_q : '0;
      assign b_q      = b_v1_q ? b_rdata_q : '0;
    end
  endgenerate

endmodule
